reg_file_scb: RTL
=================

// Module: reg_file_scb
// PURPOSE
//  Parametrised GPR file + PC for the RISC-V core: NRD combinational read ports with write-bypass,
//  one shared write port, per-register busy scoreboard for hazard detection, and PC update/link.
//  Replaces bulk async clear of the array with a one-register-per-cycle clear sweep (also soft-triggerable).
//  Sits between decode (reads/issue) and writeback (writes/jumps); control unit stalls on rs_busy/!ready.
// PARAMETERS
//  XLEN     32  data/PC width
//  NREGS    32  register count incl. x0 (power of 2, >=4); AW = $clog2(NREGS)
//  NRD      2   number of read ports
//  PC_INC   4   PC increment per non-frozen cycle
//  RESET_PC 0   PC value on reset
// PORTS
//  clk        in   1         clock, all state on posedge
//  rst_n      in   1         async active-low reset
//  halt       in   1         freeze all state (PC, array, scoreboard, clear sweep)
//  soft_clr   in   1         1-cycle pulse: start clear sweep
//  rs_addr    in   NRD*AW    read addresses, port k at [k*AW +: AW]
//  rs_data    out  NRD*XLEN  read data per port
//  rs_busy    out  NRD       scoreboard busy bit of each rs_addr
//  iss_en     in   1         instruction issued with destination iss_rd
//  iss_rd     in   AW        destination to mark busy
//  wr_en      in   1         writeback strobe
//  wr_addr    in   AW        writeback destination
//  wr_data    in   XLEN      writeback data
//  pc_load    in   1         jump/branch taken: load PC, write link
//  pc_target  in   XLEN      new PC
//  link_rd    in   AW        link destination (x0 = no link)
//  freeze_pc  in   1         hold PC this cycle
//  pc         out  XLEN      current PC
//  ready      out  1         1 in RUN, 0 during clear sweep
//  wr_drop    out  1         registered pulse: wr_en lost to pc_load last cycle
// BEHAVIOUR
//  Reset (rst_n=0): pc=RESET_PC, busy=0, wr_drop=0, state=CLEAR, clr_idx=1, ready=0. Array not reset.
//  FSM CLEAR: if !halt, rf[clr_idx]<=0, clr_idx++; at clr_idx==NREGS-1 -> RUN next cycle.
//   ready rises exactly NREGS-1 un-halted cycles after reset release. wr_en/iss_en/pc_load ignored,
//   PC held, rs_data=0, rs_busy=0. soft_clr in CLEAR restarts clr_idx=1.
//  FSM RUN: soft_clr (any halt) -> CLEAR, clr_idx=1, busy=0; PC untouched; other inputs that cycle ignored.
//  RUN, halt=1: no state changes; reads remain live.
//  PC (RUN,!halt): pc_load -> pc<=pc_target, rf[link_rd]<=pc+PC_INC (unless link_rd==0);
//   else freeze_pc -> hold; else pc<=pc+PC_INC. Arithmetic mod 2^XLEN, wraps silently.
//  Write port: pc_load takes precedence; concurrent wr_en dropped, wr_drop=1 next cycle, else wr_drop=0.
//   wr_en with wr_addr!=0 -> rf[wr_addr]<=wr_data. Writes to x0 always discarded.
//  Reads: combinational. x0 reads 0. Bypass: if same-cycle accepted write (wr_en or link) targets
//   rs_addr!=0, rs_data = that write data (wr_data or pc+PC_INC).
//  Scoreboard: iss_en & iss_rd!=0 sets busy[iss_rd]; accepted write to r clears busy[r];
//   set and clear same reg same cycle -> set wins. busy[0] constant 0. rs_busy shows pre-update value.
//  Reset mid-sweep or mid-RUN: immediate return to reset state, sweep restarts from x1.
// STRUCTURE
//  riscv_pkg: XLEN, NREGS, AW, PC_INC defaults; rf_state_t enum {RF_CLEAR, RF_RUN}.
//  Sub-module reg_file_scoreboard: busy vector, set/clear/flush, NRD lookup ports.
//  Top: array, read/bypass muxes, PC logic, clear FSM + counter.
// TESTING
//  Reset release, halt=0 -> ready=0 for 31 cycles, 1 on 32nd; all 32 reads return 0; pc=0.
//  RUN: wr x5=0xDEADBEEF while rs_addr[0]=5 -> rs_data[0]=0xDEADBEEF same cycle; write x0 -> reads 0.
//  iss_en rd=7 -> rs_busy for x7=1 next cycle; wr_en x7 + iss_en x7 same cycle -> busy stays 1.
//  pc=0x100, pc_load target=0x40, link_rd=1, wr_en x3 same cycle -> pc=0x40, x1=0x104, x3 unchanged, wr_drop=1.
//  halt=1 for 5 cycles during sweep and RUN -> pc, clr_idx, array frozen; freeze_pc holds pc.
//  soft_clr at pc=0x200 -> 31-cycle sweep, busy cleared, pc stays 0x200; rst_n low mid-sweep -> restart.

Source files
------------

// File: rtl/reg_file_scb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scb_pkg
// Description : Shared defaults and FSM encoding for the GPR file/scoreboard.
//               Provides XLEN/NREGS/NRD/PC_INC/RESET_PC defaults and the
//               two-state clear/run encoding used by reg_file_scb.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_scb_pkg;

    localparam int c_xlen_def     = 32;
    localparam int c_nregs_def    = 32;
    localparam int c_nrd_def      = 2;
    localparam int c_pc_inc_def   = 4;
    localparam int c_reset_pc_def = 0;

    // Register-file controller state: sweeping the array to zero, or running.
    typedef logic [0:0] rf_state_t;
    localparam rf_state_t c_rf_clear = 1'b0;
    localparam rf_state_t c_rf_run   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/reg_file_scb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scb_scoreboard
// Description : Per-register busy bits for hazard detection.
//               Ports: clk, rst_n (async, active-low), i_en (update enable),
//               i_flush (clear all bits, overrides i_en), i_set_en/i_set_addr
//               (mark issued destination busy), i_clr_en/i_clr_addr (writeback
//               retires destination), i_rd_addr (NRD packed lookup addresses),
//               o_rd_busy (current, pre-update busy bit per lookup).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scb_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy
);

    logic [NREGS-1:0] r_busy_q;
    logic [NREGS-1:0] w_busy_d;

    // Clear is applied before set so that an issue and a writeback to the
    // same register in one cycle leave it busy.
    always_comb begin
        w_busy_d = r_busy_q;
        if (i_flush) begin
            w_busy_d = '0;
        end else if (i_en) begin
            if (i_clr_en) w_busy_d[i_clr_addr] = 1'b0;
            if (i_set_en) w_busy_d[i_set_addr] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy_q <= '0;
        else        r_busy_q <= w_busy_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        assign o_rd_busy[k] = r_busy_q[i_rd_addr[k*AW +: AW]];
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_scb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scb
// Description : GPR file + PC for the RISC-V core. NRD combinational read
//               ports with write bypass, one shared write port (writeback or
//               jump link), busy scoreboard, PC update/link, and a
//               one-register-per-cycle clear sweep after reset or soft_clr.
//               Ports: clk, rst_n (async active-low), halt, soft_clr,
//               rs_addr/rs_data/rs_busy (read side), iss_en/iss_rd (issue),
//               wr_en/wr_addr/wr_data (writeback), pc_load/pc_target/link_rd/
//               freeze_pc (PC control), pc, ready, wr_drop.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scb
    import reg_file_scb_pkg::*;
#(
    parameter int XLEN     = c_xlen_def,
    parameter int NREGS    = c_nregs_def,
    parameter int NRD      = c_nrd_def,
    parameter int PC_INC   = c_pc_inc_def,
    parameter int RESET_PC = c_reset_pc_def,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                halt,
    input  logic                soft_clr,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                pc_load,
    input  logic [XLEN-1:0]     pc_target,
    input  logic [AW-1:0]       link_rd,
    input  logic                freeze_pc,
    output logic [XLEN-1:0]     pc,
    output logic                ready,
    output logic                wr_drop
);

    localparam logic [AW-1:0] c_clr_first = AW'(1);
    localparam logic [AW-1:0] c_clr_last  = AW'(NREGS - 1);

    logic [XLEN-1:0] r_rf [NREGS];

    rf_state_t       r_state_q,   w_state_d;
    logic [AW-1:0]   r_clr_idx_q, w_clr_idx_d;
    logic [XLEN-1:0] r_pc_q,      w_pc_d;
    logic            r_wr_drop_q, w_wr_drop_d;

    logic            w_run;
    logic            w_adv;
    logic [XLEN-1:0] w_link_data;
    logic            w_acc_en;
    logic [AW-1:0]   w_acc_addr;
    logic [XLEN-1:0] w_acc_data;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic [NRD-1:0]  w_sb_busy;

    assign w_run       = (r_state_q == c_rf_run);
    // w_adv: a normal RUN cycle in which writes, issue and PC update happen.
    assign w_adv       = w_run && !halt && !soft_clr;
    assign w_link_data = r_pc_q + XLEN'(PC_INC);

    // Accepted architectural write this cycle: the link write of a taken jump
    // wins the shared port over writeback. Writes to x0 are never accepted.
    always_comb begin
        w_acc_en   = 1'b0;
        w_acc_addr = wr_addr;
        w_acc_data = wr_data;
        if (w_adv) begin
            if (pc_load) begin
                w_acc_en   = (link_rd != '0);
                w_acc_addr = link_rd;
                w_acc_data = w_link_data;
            end else begin
                w_acc_en   = wr_en && (wr_addr != '0);
            end
        end
    end

    // Array write port is shared between the clear sweep and RUN writes.
    always_comb begin
        w_we    = w_acc_en;
        w_waddr = w_acc_addr;
        w_wdata = w_acc_data;
        if (!w_run && !halt && !soft_clr) begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx_q;
            w_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_rf[w_waddr] <= w_wdata;
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_clr_idx_d = r_clr_idx_q;
        w_pc_d      = r_pc_q;
        w_wr_drop_d = r_wr_drop_q;
        if (!w_run) begin
            w_wr_drop_d = 1'b0;
            if (soft_clr) begin
                w_clr_idx_d = c_clr_first;
            end else if (!halt) begin
                if (r_clr_idx_q == c_clr_last) w_state_d   = c_rf_run;
                else                           w_clr_idx_d = r_clr_idx_q + AW'(1);
            end
        end else if (soft_clr) begin
            w_state_d   = c_rf_clear;
            w_clr_idx_d = c_clr_first;
            w_wr_drop_d = 1'b0;
        end else if (!halt) begin
            w_wr_drop_d = wr_en && pc_load;
            if (pc_load)         w_pc_d = pc_target;
            else if (!freeze_pc) w_pc_d = w_link_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= c_rf_clear;
            r_clr_idx_q <= c_clr_first;
            r_pc_q      <= XLEN'(RESET_PC);
            r_wr_drop_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_clr_idx_q <= w_clr_idx_d;
            r_pc_q      <= w_pc_d;
            r_wr_drop_q <= w_wr_drop_d;
        end
    end

    reg_file_scb_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_adv),
        .i_flush    (w_run && soft_clr),
        .i_set_en   (iss_en && (iss_rd != '0)),
        .i_set_addr (iss_rd),
        .i_clr_en   (w_acc_en),
        .i_clr_addr (w_acc_addr),
        .i_rd_addr  (rs_addr),
        .o_rd_busy  (w_sb_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd_port
        logic [AW-1:0] w_addr;
        assign w_addr = rs_addr[k*AW +: AW];
        assign rs_data[k*XLEN +: XLEN] =
            (!w_run || (w_addr == '0))           ? '0 :
            (w_acc_en && (w_acc_addr == w_addr)) ? w_acc_data :
                                                   r_rf[w_addr];
        assign rs_busy[k] = w_run && w_sb_busy[k];
    end

    assign pc      = r_pc_q;
    assign ready   = w_run;
    assign wr_drop = r_wr_drop_q;

endmodule
`default_nettype wire
